// File: rtl/lsu_dm_bridge.sv
// lsu_dm_bridge
//   Load/store unit between the core memory stage and a word-only data memory.
//   Byte/half/word loads are turned into aligned word reads with sign/zero
//   extension. Sub-word stores use read-modify-write because the DM has only a
//   word-wide write port. Misaligned and illegal requests are rejected with a
//   one-cycle misalign_o pulse. stall_o holds the core while a request runs.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   req_i       memory request valid (sampled in IDLE only)
//   we_i        1 = store, 0 = load
//   size_i      funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i      byte address
//   wd_i        store data, LSB-aligned
//   rd_o        extended load result, registered
//   stall_o     core must hold request and pipeline
//   done_o      one-cycle pulse, request completed
//   misalign_o  one-cycle pulse, request rejected
//   mem_addr_o  word-aligned DM address (0 outside RD/MRG/WR)
//   mem_wd_o    DM write data
//   mem_we_o    DM write enable
//   mem_rd_i    DM combinational read data
module lsu_dm_bridge #(
   parameter int unsigned ADDR_W   = 32,
   parameter logic [31:0] RESET_RD = 32'h0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [2:0]        size_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wd_i,
   output logic [31:0]       rd_o,
   output logic              stall_o,
   output logic              done_o,
   output logic              misalign_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wd_o,
   output logic              mem_we_o,
   input  logic [31:0]       mem_rd_i
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      MRG,
      WR,
      DONE,
      ERR
   } state_t;

   state_t            state;
   logic [2:0]        size_q;
   logic [1:0]        off_q;
   logic [15:0]       wd_q;     // only the sub-word lanes are needed for merging
   logic [31:0]       rd_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wd_q;
   logic              mem_we_q;
   logic              done_q;
   logic              mis_q;

   logic              legal;
   logic [31:0]       shifted;
   logic [31:0]       load_ext;
   logic [31:0]       merged;

   // Legality of the request presented in the accept cycle.
   always_comb begin
      legal = 1'b0;
      case (size_i)
         3'b000, 3'b100: legal = 1'b1;
         3'b001, 3'b101: legal = ~addr_i[0];
         3'b010:         legal = (addr_i[1:0] == 2'b00);
         default:        legal = 1'b0;
      endcase
      if (we_i && size_i[2])
         legal = 1'b0;
   end

   // Lane select and extension of the DM word for loads.
   always_comb begin
      shifted  = mem_rd_i >> {off_q, 3'b000};
      load_ext = mem_rd_i;
      case (size_q)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_ext = {24'h0, shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_ext = {16'h0, shifted[15:0]};
         default: load_ext = mem_rd_i;
      endcase
   end

   // Replace the target byte/half lanes of the DM word with store data.
   always_comb begin
      merged = mem_rd_i;
      if (size_q[1:0] == 2'b00)
         merged[{off_q, 3'b000} +: 8] = wd_q[7:0];
      else
         merged[{off_q[1], 4'b0000} +: 16] = wd_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         size_q     <= '0;
         off_q      <= '0;
         wd_q       <= '0;
         rd_q       <= RESET_RD;
         mem_addr_q <= '0;
         mem_wd_q   <= '0;
         mem_we_q   <= 1'b0;
         done_q     <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         mis_q    <= 1'b0;
         mem_we_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i) begin
                  size_q <= size_i;
                  off_q  <= addr_i[1:0];
                  wd_q   <= wd_i[15:0];
                  if (!legal) begin
                     state <= ERR;
                     mis_q <= 1'b1;
                  end else begin
                     mem_addr_q <= {addr_i[ADDR_W-1:2], 2'b00};
                     if (!we_i) begin
                        state <= RD;
                     end else if (size_i[1:0] == 2'b10) begin
                        state    <= WR;
                        mem_we_q <= 1'b1;
                        mem_wd_q <= wd_i;
                     end else begin
                        state <= MRG;
                     end
                  end
               end
            end
            RD: begin
               rd_q       <= load_ext;
               mem_addr_q <= '0;
               done_q     <= 1'b1;
               state      <= DONE;
            end
            MRG: begin
               mem_wd_q <= merged;
               mem_we_q <= 1'b1;
               state    <= WR;
            end
            WR: begin
               mem_addr_q <= '0;
               done_q     <= 1'b1;
               state      <= DONE;
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign rd_o       = rd_q;
   assign done_o     = done_q;
   assign misalign_o = mis_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_wd_o   = mem_wd_q;
   // Gating with reset keeps a pending write from reaching DM in the reset cycle.
   assign mem_we_o   = mem_we_q & ~rst_i;
   assign stall_o    = ((state == IDLE) && req_i) || (state == RD) ||
                       (state == MRG) || (state == WR);

endmodule

// File: tb/tb_lsu_dm_bridge.sv
module tb_lsu_dm_bridge;

   localparam logic [31:0] RST_VAL = 32'h5A5A_0001;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [2:0]  size;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd_o;
   logic        stall_o;
   logic        done_o;
   logic        misalign_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic        mem_we_o;
   logic [31:0] mem_rd_i;

   lsu_dm_bridge #(.ADDR_W(32), .RESET_RD(RST_VAL)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .we_i       (we),
      .size_i     (size),
      .addr_i     (addr),
      .wd_i       (wd),
      .rd_o       (rd_o),
      .stall_o    (stall_o),
      .done_o     (done_o),
      .misalign_o (misalign_o),
      .mem_addr_o (mem_addr_o),
      .mem_wd_o   (mem_wd_o),
      .mem_we_o   (mem_we_o),
      .mem_rd_i   (mem_rd_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory driven by the DUT, plus an independent reference image.
   logic [31:0] dm [256];
   logic [31:0] ref_mem [256];
   logic        dm_init;

   function automatic logic [31:0] init_word(input int i);
      return (i == 0) ? 32'h8899AABB : (32'h01010101 * i) ^ 32'hC3000000;
   endfunction

   always @(posedge clk) begin
      if (dm_init) begin
         for (int i = 0; i < 256; i++) dm[i] <= init_word(i);
      end else if (mem_we_o) begin
         dm[mem_addr_o[9:2]] <= mem_wd_o;
      end
   end
   assign mem_rd_i = dm[mem_addr_o[9:2]];

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit          err;
      int          lat;
      int          stall;
      int          wec;
      int          welat;
      logic [31:0] wd;
      logic [31:0] waddr;
      logic [31:0] rd;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] model_rd;

   // Reference behaviour; also updates the reference memory and load result.
   function automatic exp_t model(input logic w, input logic [2:0] sz,
                                  input logic [31:0] a, input logic [31:0] d);
      exp_t        e;
      bit          ok;
      int          s;
      logic [31:0] word, sh, mask;
      e = '{default: 0};
      case (sz)
         3'd0, 3'd4: ok = 1;
         3'd1, 3'd5: ok = (a[0] == 1'b0);
         3'd2:       ok = (a[1:0] == 2'b00);
         default:    ok = 0;
      endcase
      if (w && sz[2]) ok = 0;
      word    = ref_mem[a[9:2]];
      s       = 8 * int'(a[1:0]);
      sh      = word >> s;
      e.waddr = {a[31:2], 2'b00};
      if (!ok) begin
         e.err = 1; e.lat = 1; e.stall = 1;
      end else if (!w) begin
         e.lat = 2; e.stall = 2;
         case (sz)
            3'd0:    model_rd = {{24{sh[7]}}, sh[7:0]};
            3'd4:    model_rd = {24'h0, sh[7:0]};
            3'd1:    model_rd = {{16{sh[15]}}, sh[15:0]};
            3'd5:    model_rd = {16'h0, sh[15:0]};
            default: model_rd = word;
         endcase
      end else if (sz == 3'd2) begin
         e.lat = 2; e.stall = 2; e.wec = 1; e.welat = 1; e.wd = d;
         ref_mem[a[9:2]] = d;
      end else begin
         mask  = ((sz == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << s;
         e.lat = 3; e.stall = 3; e.wec = 1; e.welat = 2;
         e.wd  = (word & ~mask) | ((d << s) & mask);
         ref_mem[a[9:2]] = e.wd;
      end
      e.rd = model_rd;
      return e;
   endfunction

   task automatic issue(input string tag, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
      exp_t e, g;
      bit   fin;
      sb.push_back(model(w, sz, a, d));
      g   = '{default: 0};
      fin = 0;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; addr = a; wd = d;
      for (int k = 0; k < 8 && !fin; k++) begin
         #1;
         if (stall_o) g.stall++;
         if (mem_we_o) begin
            g.wec++; g.welat = k; g.wd = mem_wd_o; g.waddr = mem_addr_o;
         end
         if (done_o || misalign_o) begin
            fin = 1; g.err = misalign_o; g.lat = k; g.rd = rd_o;
            chk({tag, ":both_pulses"}, {31'h0, done_o & misalign_o}, 32'h0);
         end else begin
            @(negedge clk);
            req = 1'b0;
         end
      end
      req = 1'b0;
      chk({tag, ":completed"}, {31'h0, fin}, 32'h1);
      e = sb.pop_front();
      chk({tag, ":misalign"}, {31'h0, g.err}, {31'h0, e.err});
      chk({tag, ":latency"}, g.lat, e.lat);
      chk({tag, ":stall_cycles"}, g.stall, e.stall);
      chk({tag, ":we_count"}, g.wec, e.wec);
      if (e.wec == 1) begin
         chk({tag, ":we_cycle"}, g.welat, e.welat);
         chk({tag, ":wdata"}, g.wd, e.wd);
         chk({tag, ":waddr"}, g.waddr, e.waddr);
      end
      chk({tag, ":rd"}, g.rd, e.rd);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      model_rd = RST_VAL;
      rst = 1'b1; dm_init = 1'b1;
      req = 1'b0; we = 1'b0; size = '0; addr = '0; wd = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0; dm_init = 1'b0;
      #1;
      chk("rst:rd", rd_o, RST_VAL);
      chk("rst:done", {31'h0, done_o}, 32'h0);
      chk("rst:misalign", {31'h0, misalign_o}, 32'h0);
      chk("rst:mem_we", {31'h0, mem_we_o}, 32'h0);
      chk("rst:mem_addr", mem_addr_o, 32'h0);
      chk("rst:mem_wd", mem_wd_o, 32'h0);
      chk("rst:stall", {31'h0, stall_o}, 32'h0);

      issue("LB_1001",  0, 3'b000, 32'h1001, 32'h0);
      issue("LBU_1001", 0, 3'b100, 32'h1001, 32'h0);
      issue("LH_1002",  0, 3'b001, 32'h1002, 32'h0);
      issue("LHU_1002", 0, 3'b101, 32'h1002, 32'h0);
      issue("LW_1000",  0, 3'b010, 32'h1000, 32'h0);
      issue("SB_1003",  1, 3'b000, 32'h1003, 32'h12345677);
      issue("LW_rmw",   0, 3'b010, 32'h1000, 32'h0);
      issue("LW_1002",  0, 3'b010, 32'h1002, 32'h0);
      issue("SH_1001",  1, 3'b001, 32'h1001, 32'h0000BEEF);
      issue("SZ_011",   0, 3'b011, 32'h1000, 32'h0);
      issue("SBU_ill",  1, 3'b100, 32'h1000, 32'h0);
      issue("SH_1002",  1, 3'b001, 32'h1002, 32'h1111CAFE);
      issue("LH_cafe",  0, 3'b001, 32'h1002, 32'h0);

      // Reset during the MRG cycle of SH 0x1000: write must be abandoned.
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 3'b001; addr = 32'h1000; wd = 32'h0000F00D;
      @(negedge clk);
      req = 1'b0;
      #1 chk("rstmrg:stall", {31'h0, stall_o}, 32'h1);
      rst = 1'b1;
      #1 chk("rstmrg:we_in_rst", {31'h0, mem_we_o}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      model_rd = RST_VAL;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rstmrg:we", {31'h0, mem_we_o}, 32'h0);
         chk("rstmrg:pulses", {30'h0, done_o, misalign_o}, 32'h0);
         chk("rstmrg:stall_idle", {31'h0, stall_o}, 32'h0);
         @(negedge clk);
      end
      chk("rstmrg:rd", rd_o, RST_VAL);
      chk("rstmrg:dm_word", dm[0], ref_mem[0]);

      issue("SW_1004", 1, 3'b010, 32'h1004, 32'hDEADBEEF);
      issue("LW_1004", 0, 3'b010, 32'h1004, 32'h0);

      for (int n = 0; n < 12; n++) begin
         logic [2:0] szs [6];
         szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
         issue("rand", 1'($urandom_range(0, 1)), szs[$urandom_range(0, 5)],
               32'h1000 + $urandom_range(0, 15), $urandom);
      end

      chk("final:dm0", dm[0], ref_mem[0]);
      chk("final:dm1", dm[1], ref_mem[1]);
      chk("final:dm2", dm[2], ref_mem[2]);
      chk("final:dm3", dm[3], ref_mem[3]);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
